// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: turns one burst request into single-cycle accesses on a
// synchronous-read RAM port. Writes are paced by a valid/ready data stream.
// Reads issue one access per cycle. Responses come out one cycle behind their
// accesses. No access ever targets an address above the request's upper
// bound. Addresses never wrap past all-ones back to zero.
module ram_burst_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    // Request channel
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [ADDR_W-1:0] req_max,

    // Write data stream
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,

    // RAM port
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,

    // Read response stream (cannot be stalled)
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,

    // Error reporting
    output logic              err_range,
    output logic [7:0]        err_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]  beats_left_q, beats_left_d;
    logic [ADDR_W-1:0] max_q, max_d;

    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_last_q, rsp_last_d;
    logic              err_range_q, err_range_d;
    logic [7:0]        err_count_q, err_count_d;

    // Per-beat termination conditions, all derived from the current beat.
    logic              at_max;
    logic              at_top;
    logic              more_beats;
    logic              beat_last;
    logic              beat_trunc;
    logic              beat_fire;

    assign at_max     = (cur_addr_q == max_q);
    assign at_top     = (cur_addr_q == {ADDR_W{1'b1}});
    assign more_beats = (beats_left_q != '0);
    // A beat ends the burst if the count is exhausted, or if the next address
    // would exceed the bound or wrap past all-ones.
    assign beat_last  = !more_beats || at_max || at_top;
    // Ending early while beats remain is a truncation and is reported.
    assign beat_trunc = more_beats && (at_max || at_top);

    // Next-state, datapath updates and combinational handshake/RAM outputs.
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        max_d        = max_q;
        rsp_valid_d  = 1'b0;
        rsp_last_d   = 1'b0;
        err_range_d  = 1'b0;
        req_ready    = 1'b0;
        wd_ready     = 1'b0;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_wdata    = '0;
        beat_fire    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Held low while reset is asserted so nothing is accepted
                // before the block is out of reset.
                req_ready = rst_n;
                if (req_valid && rst_n) begin
                    cur_addr_d   = req_addr;
                    beats_left_d = req_len;
                    max_d        = req_max;
                    if (req_addr > req_max) begin
                        // Start already out of range: reject, no access.
                        err_range_d = 1'b1;
                    end else if (req_write) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end

            WRITE: begin
                wd_ready = 1'b1;
                if (wd_valid) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_wdata = wd_data;
                    beat_fire = 1'b1;
                end
            end

            READ: begin
                ram_en      = 1'b1;
                beat_fire   = 1'b1;
                // The response for this access appears next cycle.
                rsp_valid_d = 1'b1;
                rsp_last_d  = beat_last;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (beat_fire) begin
            if (beat_last) begin
                state_d     = IDLE;
                err_range_d = beat_trunc;
            end else begin
                cur_addr_d   = cur_addr_q + ADDR_W'(1);
                beats_left_d = beats_left_q - LEN_W'(1);
            end
        end
    end

    // Error counter increments on every pulse and saturates at its maximum.
    always_comb begin
        err_count_d = err_count_q;
        if (err_range_q && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // State and burst bookkeeping registers; reset abandons any burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            max_q        <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
            max_q        <= max_d;
        end
    end

    // Registered response and error outputs; reset drops a pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            err_range_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            err_range_q <= err_range_d;
            err_count_q <= err_count_d;
        end
    end

    assign ram_addr  = cur_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_last  = rsp_last_q;
    // The RAM itself supplies the one-cycle register stage on read data, so
    // the response data follows ram_rdata, qualified by the registered valid.
    // It is zero whenever no response is valid, including during reset.
    assign rsp_data  = rsp_valid_q ? ram_rdata : '0;
    assign err_range = err_range_q;
    assign err_count = err_count_q;

endmodule

// File: doc/ram_burst_ctrl.md
# ram_burst_ctrl

Burst access controller that sits directly upstream of the 8-bit-address RAM and drives its `Addr`/`Data` port. It turns one request (start address, length, direction, upper bound `Max`) into a sequence of single-cycle RAM accesses. Write data comes in on a valid/ready stream; read data goes out on a response stream. No access ever targets an address above `Max`, which is the same property the RAM-side address checker asserts.

## Interface

Parameters:
- `ADDR_W`, 8, RAM address width.
- `DATA_W`, 8, RAM data width.
- `LEN_W`, 4, burst length field width; the burst is `req_len+1` beats (1..16).

Ports:
- `clk`  in  1  sole clock; everything is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_write`  in  1  1 = write burst, 0 = read burst.
- `req_addr`  in  `ADDR_W`  start address.
- `req_len`  in  `LEN_W`  beats minus one.
- `req_max`  in  `ADDR_W`  highest permitted address for this burst.
- `wd_valid`  in  1  write data beat offered.
- `wd_ready`  out  1  write data beat accepted.
- `wd_data`  in  `DATA_W`  write data.
- `ram_en`  out  1  RAM access this cycle.
- `ram_we`  out  1  write strobe; only meaningful when `ram_en`=1.
- `ram_addr`  out  `ADDR_W`  RAM address.
- `ram_wdata`  out  `DATA_W`  RAM write data.
- `ram_rdata`  in  `DATA_W`  RAM read data; valid one cycle after a read access.
- `rsp_valid`  out  1  read response beat; the consumer cannot stall it.
- `rsp_data`  out  `DATA_W`  read response data.
- `rsp_last`  out  1  final response beat of the burst.
- `err_range`  out  1  one-cycle pulse when a request is rejected or a burst is truncated.
- `err_count`  out  8  number of `err_range` pulses, saturating at 255.

## Operation

State machine states: IDLE, WRITE, READ.

IDLE:
- `req_ready`=1.
- On accept, latch `req_write`, `req_addr`, `req_len`, `req_max` into `cur_addr`, `beats_left`, `max_q`.
- If `req_addr > req_max`: pulse `err_range` in the cycle after the accept, issue no access, and stay in IDLE.
- Otherwise go to WRITE or READ according to `req_write`.

WRITE:
- `wd_ready`=1.
- Each handshake drives `ram_en`=1, `ram_we`=1, `ram_addr`=`cur_addr`, `ram_wdata`=`wd_data` combinationally.
- When `wd_valid`=0, `ram_en`=0 and no state changes.

READ:
- One access per cycle with `ram_en`=1, `ram_we`=0.
- The beat issued in cycle N produces `rsp_valid`=1 and `rsp_data`=`ram_rdata` in cycle N+1.

Every issued beat:
- The beat is the last one if any of these holds:
  - `beats_left`=0;
  - `cur_addr`=`max_q` with `beats_left`>0 (truncation);
  - `cur_addr`=all-ones with `beats_left`>0 (truncation; addresses never wrap to 0).
- On a last beat, return to IDLE. For reads, the matching response carries `rsp_last`=1.
- Otherwise `cur_addr`+1 and `beats_left`-1.
- On truncation, `err_range` pulses in the cycle after the last beat is issued.

Error counter:
- `err_count` increments on every `err_range` pulse and holds at 255.

## Timing

Reset:
- Reset is asynchronous: `rst_n` low clears the block at once, with no clock needed.
- State goes to IDLE.
- All registered outputs go to 0: `rsp_valid`, `rsp_data`, `rsp_last`, `err_range`, `err_count`.
- `ram_addr` goes to 0 (`cur_addr` cleared).
- `ram_en`, `ram_we`, `wd_ready` go to 0.
- `req_ready` is 0 while `rst_n` is low and 1 from the first cycle after release.

Reset during a burst:
- The burst is abandoned.
- A read response that was due in the next cycle is dropped; `rsp_valid` stays 0.

Latency:
- Request accepted at cycle T: first RAM access no earlier than T+1.
- Read response arrives one cycle after its access.
- A full 16-beat read occupies T+1..T+16; responses appear at T+2..T+17.
- Back-to-back: IDLE accepts a new request in the cycle after the last beat. The final response of the previous read overlaps that IDLE cycle, and this is legal.

Output timing:
- `err_range` is registered and is high for exactly one cycle per event.
- `req_ready`, `wd_ready`, `ram_*` are combinational from state and inputs. `rsp_*` is registered.

## Test plan

- Write burst: addr=0x10, len=3, max=0xFF, `wd_valid` held high with data 0xA0..0xA3 -> `ram_we` on 4 consecutive cycles at addresses 0x10..0x13, `err_range` never high.
- Write with gaps: toggle `wd_valid` every other cycle -> accesses only on handshake cycles, the address advances only on handshakes, the burst completes after 4 handshakes.
- Read burst: addr=0x20, len=15, max=0xFF, RAM model returns addr^0x55 -> 16 `rsp_valid` beats one cycle behind the accesses, `rsp_last` only on the beat for 0x2F.
- Truncation: addr=0x7E, len=7, max=0x80 -> 3 accesses (0x7E..0x80), `rsp_last` on the response for 0x80, one `err_range` pulse, `err_count`=1. Then addr=0xFE, len=3, max=0xFF -> 2 accesses, no wrap to 0x00, `err_count`=2.
- Rejection: addr=0x90, max=0x8F -> no `ram_en`, `err_range` pulses once, the block is back in IDLE with `req_ready`=1. 300 such requests -> `err_count` saturates at 255.
- Reset mid-read: assert `rst_n` low during beat 5 of 16 -> all outputs 0 immediately, no further `rsp_valid`. After release, a new read burst runs correctly.
